// File: rtl/core_pkg.sv
// Shared core types and constants used by fetch and decode.
// No logic; types and parameters only.
// Not applicable: no handshake lives in a package.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h01000000;
    localparam logic [XLEN-1:0] INSN_NOP = 32'h00000013;

    // One fetched instruction paired with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched entries between fetch and decode.
// Head visible combinationally from storage; push/pop/flush take effect on the rising edge.
// Push is ignored when full at the start of the cycle (a same-cycle pop does not free space); flush wins over push/pop.
module fetch_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entries [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualify requests against the occupancy seen at the start of the cycle.
    always_comb begin
        do_push = push && (count != 2'd2);
        do_pop  = pop && (count != 2'd0);
        head    = entries[rd_ptr];
    end

    // Storage, pointers and occupancy; flush only rewinds pointers, contents go stale.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, combinational imem read, 2-entry buffer to decode.
// First instruction reaches decode one edge after reset release; a redirect costs two edges.
// Decode stalls via d_ready; once the buffer is full the PC freezes. Redirect flushes and masks f_valid.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_insn,
    input  logic        d_ready,
    output logic        misaligned
);

    logic [31:0]  pc;
    logic [1:0]   count;
    logic         push;
    logic         pop;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic [63:0]  head_bits;

    // Push only into free space and never in a redirect cycle; redirect also hides the head.
    always_comb begin
        push            = (count != 2'd2) && !redirect_valid;
        f_valid         = (count != 2'd0) && !redirect_valid;
        pop             = f_valid && d_ready;
        push_entry.pc   = pc;
        push_entry.insn = imem_data;
        head_entry      = fetch_entry_t'(head_bits);
        f_pc            = head_entry.pc;
        f_insn          = head_entry.insn;
        imem_address    = pc;
    end

    fetch_buffer #(
        .WIDTH($bits(fetch_entry_t))
    ) u_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head_bits)
    );

    // PC: redirect reloads a word-aligned target, otherwise advance on every accepted push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_target[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    // Sticky record of any redirect to a non-word-aligned target.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end

endmodule
